dac_serial_tx: RTL and testbench

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

---
 rtl/dac_serial_tx.sv | 178 +++++++++++++++++
 tb/tb_dac_serial_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : dac_serial_tx
// Description : Serial transmitter for a 16-bit-frame DAC. Each accepted
//               18-bit signed sample is rounded to 12 bits, saturated, and
//               stored in offset binary in a one-entry holding buffer. The
//               word {CTRL, data} is shifted out MSB first while sync_n is
//               low. sclk idles high, and sdo changes only on its rising
//               edge, so the DAC samples on the falling edge. A 2*CLK_DIV
//               gap separates frames.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active low
//               sample     - signed 18-bit input sample
//               in_valid   - sample is valid
//               in_ready   - holding buffer is empty
//               sclk       - DAC serial clock (idles high)
//               sync_n     - frame enable, active low
//               sdo        - serial data, MSB first
//               busy       - frame in progress (SHIFT or GAP)
//               frame_done - one-cycle pulse after the 16th bit
// Revision    : 1.0 - initial release
// ============================================================================
module dac_serial_tx #(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CTRL    = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sample,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdo,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic        buf_full_q,   buf_full_d;
    logic [11:0] buf_q,        buf_d;
    logic [15:0] shifter_q,    shifter_d;
    logic [7:0]  div_q,        div_d;
    logic [3:0]  bit_cnt_q,    bit_cnt_d;
    logic        sclk_q,       sclk_d;
    logic        sync_n_q,     sync_n_d;
    logic        sdo_q,        sdo_d;
    logic        frame_done_q, frame_done_d;

    logic signed [12:0] rnd;
    logic               sat;
    logic [11:0]        conv;
    logic               tick;
    logic               accept;
    logic               load;
    logic               unused_lsbs;

    // Round half-up on bit 5. Only positive overflow is possible
    // (2047 + 1), which shows up as bits [12:11] == 2'b01.
    assign rnd  = $signed({sample[17], sample[17:6]}) + $signed({12'b0, sample[5]});
    assign sat  = ~rnd[12] & rnd[11];
    assign conv = sat ? 12'hFFF : (rnd[11:0] ^ 12'h800);
    assign unused_lsbs = ^sample[4:0];

    assign tick   = (div_q == DIV_LAST);
    assign accept = in_valid & ~buf_full_q;
    // A buffered sample starts a frame either from IDLE or directly at the
    // end of GAP, so back-to-back frames have no idle cycle between them.
    assign load   = buf_full_q & ((state_q == IDLE) |
                                  ((state_q == GAP) & tick & bit_cnt_q[0]));

    always_comb begin
        state_d      = state_q;
        buf_full_d   = buf_full_q;
        buf_d        = buf_q;
        shifter_d    = shifter_q;
        div_d        = (state_q == IDLE) ? 8'd0 : (tick ? 8'd0 : div_q + 8'd1);
        bit_cnt_d    = bit_cnt_q;
        sclk_d       = sclk_q;
        sync_n_d     = sync_n_q;
        sdo_d        = sdo_q;
        frame_done_d = 1'b0;

        case (state_q)
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == 4'd15) begin
                        sclk_d       = 1'b1;
                        sync_n_d     = 1'b1;
                        sdo_d        = 1'b0;
                        frame_done_d = 1'b1;
                        bit_cnt_d    = 4'd0;
                        state_d      = GAP;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shifter_d = {shifter_q[14:0], 1'b0};
                        sdo_d     = shifter_q[14];
                    end
                end
            end
            GAP: begin
                // Two divider wraps make up the gap; bit_cnt[0] marks the first.
                if (tick) begin
                    if (bit_cnt_q[0]) begin
                        bit_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (load) begin
            shifter_d  = {CTRL, buf_q};
            sdo_d      = CTRL[3];
            sync_n_d   = 1'b0;
            sclk_d     = 1'b1;
            div_d      = 8'd0;
            bit_cnt_d  = 4'd0;
            buf_full_d = 1'b0;
            state_d    = SHIFT;
        end

        if (accept) begin
            buf_full_d = 1'b1;
            buf_d      = conv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            buf_full_q   <= 1'b0;
            buf_q        <= 12'd0;
            shifter_q    <= 16'd0;
            div_q        <= 8'd0;
            bit_cnt_q    <= 4'd0;
            sclk_q       <= 1'b1;
            sync_n_q     <= 1'b1;
            sdo_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_full_q   <= buf_full_d;
            buf_q        <= buf_d;
            shifter_q    <= shifter_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            sclk_q       <= sclk_d;
            sync_n_q     <= sync_n_d;
            sdo_q        <= sdo_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = ~buf_full_q;
    assign sclk       = sclk_q;
    assign sync_n     = sync_n_q;
    assign sdo        = sdo_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_serial_tx
// Description : Directed testbench for dac_serial_tx (CLK_DIV=4, CTRL=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_serial_tx;

    logic        clk;
    logic        rst;
    logic [17:0] sample;
    logic        in_valid;
    logic        in_ready;
    logic        sclk;
    logic        sync_n;
    logic        sdo;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    dac_serial_tx #(
        .CLK_DIV (4),
        .CTRL    (4'b0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample     (sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sclk       (sclk),
        .sync_n     (sync_n),
        .sdo        (sdo),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a sample from a falling edge until it is accepted. With scr
    // set, junk values are driven while in_ready is low and the real value
    // appears only once in_ready is high.
    task automatic offer(input logic [17:0] s, input bit scr);
        int cnt;
        cnt = 0;
        in_valid = 1'b1;
        sample = (scr && in_ready !== 1'b1) ? 18'($urandom) : s;
        while (in_ready !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            sample = (scr && in_ready !== 1'b1) ? 18'($urandom) : s;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL offer_accept: in_ready=%b required 1 within 1000 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Observe one frame on the serial pins, sampling sdo at sclk falls.
    task automatic capture(output logic [15:0] word, output int lowcnt, output int waited,
                           output logic fd_end, output logic fd_next,
                           output int fd_early, output int busy_bad, output bit tmo);
        logic prev;
        word = 16'd0; lowcnt = 0; waited = 0; fd_early = 0; busy_bad = 0;
        tmo = 1'b0; fd_end = 1'b0; fd_next = 1'b0;
        @(negedge clk);
        while (sync_n !== 1'b0 && waited < 2000) begin
            waited++;
            @(negedge clk);
        end
        if (sync_n !== 1'b0) begin
            tmo = 1'b1;
            return;
        end
        prev = 1'b1;
        while (sync_n === 1'b0 && lowcnt < 2000) begin
            lowcnt++;
            if (prev === 1'b1 && sclk === 1'b0) word = {word[14:0], sdo};
            prev = sclk;
            if (frame_done !== 1'b0) fd_early++;
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        if (lowcnt >= 2000) tmo = 1'b1;
        fd_end = frame_done;
        @(negedge clk);
        fd_next = frame_done;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; sample = 18'd0;
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (sclk !== 1'b1)       begin n_err++; $display("FAIL rst_sclk: got %b want 1", sclk); end
        n_cmp++; if (sync_n !== 1'b1)     begin n_err++; $display("FAIL rst_sync_n: got %b want 1", sync_n); end
        n_cmp++; if (sdo !== 1'b0)        begin n_err++; $display("FAIL rst_sdo: got %b want 0", sdo); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // No frame may start without an accept.
        repeat (10) @(negedge clk);
        n_cmp++; if (sync_n !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL post_rst_idle: sync_n=%b busy=%b want 1/0", sync_n, busy);
        end
    endtask

    task automatic test_basic_frame;
        logic [15:0] w; int lc, wt, fe, bb; logic fd1, fd2; bit tmo;
        fork
            offer(18'd0, 1'b0);
            capture(w, lc, wt, fd1, fd2, fe, bb, tmo);
        join
        n_cmp++; if (tmo !== 1'b0)    begin n_err++; $display("FAIL basic_timeout: got %b want 0", tmo); end
        n_cmp++; if (w !== 16'h0800)  begin n_err++; $display("FAIL basic_word: got %h want 0800", w); end
        n_cmp++; if (lc !== 128)      begin n_err++; $display("FAIL basic_sync_low: got %0d want 128", lc); end
        n_cmp++; if (fd1 !== 1'b1 || fe !== 0) begin
            n_err++; $display("FAIL basic_fd_at_128: got end=%b early=%0d want 1/0", fd1, fe);
        end
        n_cmp++; if (fd2 !== 1'b0)    begin n_err++; $display("FAIL basic_fd_width: got %b want 0", fd2); end
        n_cmp++; if (bb !== 0)        begin n_err++; $display("FAIL basic_busy: got %0d low cycles want 0", bb); end
        // GAP: busy through cycle 8 after sync_n rises, idle afterwards.
        repeat (6) @(negedge clk);
        n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL gap_busy: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || sdo !== 1'b0) begin
            n_err++; $display("FAIL gap_end_idle: busy=%b sdo=%b want 0/0", busy, sdo);
        end
    endtask

    task automatic test_conversion;
        logic [17:0] s_tab [4];
        logic [15:0] e_tab [4];
        logic [15:0] w; int lc, wt, fe, bb; logic fd1, fd2; bit tmo;
        s_tab[0] = 18'h1FFFF; e_tab[0] = 16'h0FFF;
        s_tab[1] = 18'h20000; e_tab[1] = 16'h0000;
        s_tab[2] = 18'sd32;   e_tab[2] = 16'h0801;
        s_tab[3] = 18'h1FFE0; e_tab[3] = 16'h0FFF;
        for (int i = 0; i < 4; i++) begin
            fork
                offer(s_tab[i], 1'b0);
                capture(w, lc, wt, fd1, fd2, fe, bb, tmo);
            join
            n_cmp++; if (tmo !== 1'b0 || w !== e_tab[i]) begin
                n_err++; $display("FAIL conv_%0d: sample=%h got %h (tmo=%b) want %h", i, s_tab[i], w, tmo, e_tab[i]);
            end
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w1, w2; int lc1, lc2, wt1, wt2, fe1, fe2, bb1, bb2;
        logic fa1, fa2, fb1, fb2; bit t1, t2;
        logic rdy_after, busy_after, sync_at_rdy; int rcnt;
        fork
            begin
                offer(18'sd32, 1'b0);
                offer(18'h20000, 1'b0);
                rdy_after = in_ready; busy_after = busy;
                rcnt = 0;
                while (in_ready !== 1'b1 && rcnt < 500) begin
                    @(negedge clk);
                    rcnt++;
                end
                sync_at_rdy = sync_n;
            end
            begin
                capture(w1, lc1, wt1, fa1, fb1, fe1, bb1, t1);
                capture(w2, lc2, wt2, fa2, fb2, fe2, bb2, t2);
            end
        join
        n_cmp++; if (t1 !== 1'b0 || t2 !== 1'b0) begin n_err++; $display("FAIL b2b_timeout: got %b%b want 00", t1, t2); end
        n_cmp++; if (w1 !== 16'h0801) begin n_err++; $display("FAIL b2b_word1: got %h want 0801", w1); end
        n_cmp++; if (w2 !== 16'h0000) begin n_err++; $display("FAIL b2b_word2: got %h want 0000", w2); end
        n_cmp++; if (rdy_after !== 1'b0 || busy_after !== 1'b1) begin
            n_err++; $display("FAIL b2b_held: in_ready=%b busy=%b want 0/1", rdy_after, busy_after);
        end
        n_cmp++; if (sync_at_rdy !== 1'b0 || rcnt >= 500) begin
            n_err++; $display("FAIL b2b_ready_at_load: sync_n=%b cycles=%0d want 0 and <500", sync_at_rdy, rcnt);
        end
        // capture() consumed two high cycles after frame 1 before waiting.
        n_cmp++; if (wt2 + 2 !== 8)   begin n_err++; $display("FAIL b2b_gap: got %0d want 8", wt2 + 2); end
        n_cmp++; if (lc2 !== 128 || fa2 !== 1'b1) begin
            n_err++; $display("FAIL b2b_frame2: low=%0d fd=%b want 128/1", lc2, fa2);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_stall;
        logic [15:0] w1, w2, w3; int lc, wt, fe, bb; logic fd1, fd2; bit t1, t2, t3;
        fork
            begin
                offer(18'sd32, 1'b0);
                offer(18'h20000, 1'b0);
                offer(18'h1FFFF, 1'b1);
            end
            begin
                capture(w1, lc, wt, fd1, fd2, fe, bb, t1);
                capture(w2, lc, wt, fd1, fd2, fe, bb, t2);
                capture(w3, lc, wt, fd1, fd2, fe, bb, t3);
            end
        join
        n_cmp++; if (t1 | t2 | t3)    begin n_err++; $display("FAIL stall_timeout: got %b%b%b want 000", t1, t2, t3); end
        n_cmp++; if (w1 !== 16'h0801 || w2 !== 16'h0000) begin
            n_err++; $display("FAIL stall_first_two: got %h %h want 0801 0000", w1, w2);
        end
        n_cmp++; if (w3 !== 16'h0FFF) begin n_err++; $display("FAIL stall_third: got %h want 0FFF", w3); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w; int lc, wt, fe, bb, cnt, fd_seen, sync_seen; logic fd1, fd2; bit tmo;
        offer(18'h1FFFF, 1'b0);
        cnt = 0;
        while (sync_n !== 1'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL midrst_start: sync_n=%b want 0", sync_n); end
        offer(18'h20000, 1'b0);      // buffered, must be discarded by reset
        repeat (55) @(negedge clk);  // 57 cycles into the frame: bit 7
        rst = 1'b0;
        #1;
        n_cmp++; if (sync_n !== 1'b1 || sclk !== 1'b1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_async: sync_n=%b sclk=%b in_ready=%b want 1/1/1", sync_n, sclk, in_ready);
        end
        n_cmp++; if (busy !== 1'b0 || sdo !== 1'b0) begin
            n_err++; $display("FAIL midrst_busy_sdo: busy=%b sdo=%b want 0/0", busy, sdo);
        end
        fd_seen = 0; sync_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done !== 1'b0) fd_seen++;
        end
        rst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (frame_done !== 1'b0) fd_seen++;
            if (sync_n !== 1'b1) sync_seen++;
        end
        n_cmp++; if (fd_seen !== 0)   begin n_err++; $display("FAIL midrst_no_fd: got %0d pulses want 0", fd_seen); end
        n_cmp++; if (sync_seen !== 0) begin n_err++; $display("FAIL midrst_no_frame: got %0d low cycles want 0", sync_seen); end
        fork
            offer(18'sd32, 1'b0);
            capture(w, lc, wt, fd1, fd2, fe, bb, tmo);
        join
        n_cmp++; if (tmo !== 1'b0 || w !== 16'h0801 || lc !== 128) begin
            n_err++; $display("FAIL midrst_next_frame: word=%h low=%0d tmo=%b want 0801/128/0", w, lc, tmo);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_conversion();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
